// File: rtl/oled_gpio_pkg.sv
// oled_gpio_pkg
// Shared definitions for the OLED GPIO sequencer:
//   - seq_state_t   : reset-sequencer state encoding (also the status code)
//   - CTRL_*        : bit positions in gpio_oled_control
//   - STAT_*        : bit positions in gpio_oled_status
//   - max_int()     : helper for sizing the shared sequence counter
package oled_gpio_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_READY  = 2'd2,
        ST_UNUSED = 2'd3   // never entered; recovers to ST_ASSERT
    } seq_state_t;

    // Control word bit positions
    localparam int CTRL_DC      = 0;
    localparam int CTRL_RST_MAN = 1;
    localparam int CTRL_RST_REQ = 2;
    localparam int CTRL_CD_CLR  = 3;
    localparam int CTRL_CS_BASE = 4;
    localparam int CTRL_IRQ_EN  = 31;

    // Status word bit positions
    localparam int STAT_CD       = 0;
    localparam int STAT_DC       = 1;
    localparam int STAT_RST      = 2;
    localparam int STAT_BUSY     = 3;
    localparam int STAT_CD_EVENT = 4;
    localparam int STAT_READY    = 5;
    localparam int STAT_STATE_LO = 6;
    localparam int STAT_STATE_HI = 7;
    localparam int STAT_SIG_LO   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oled_cd_debounce.sv
// oled_cd_debounce
// Synchronises the asynchronous SD card-detect pin with two flops and
// debounces it: the accepted level only changes after the synchronised input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cd_async      : raw card-detect pin
//   cd_debounced  : accepted card-detect level (resets to 1)
//   cd_flip       : combinational, high in the cycle whose closing edge
//                   flips cd_debounced; lets the parent register an event
//                   on the same edge as the level change
module oled_cd_debounce
    import oled_gpio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic cd_async,
    output logic cd_debounced,
    output logic cd_flip
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             deb_reg;
    logic             deb_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // The counter value DEBOUNCE_CYCLES is held for one cycle before the
    // flip, giving 2 + DEBOUNCE_CYCLES + 1 cycles of pin-to-level latency.
    assign cd_flip = (sync2_reg != deb_reg) && (cnt_reg == CNT_LAST);

    always_comb begin
        deb_next = deb_reg;
        cnt_next = cnt_reg;
        if (sync2_reg == deb_reg) begin
            cnt_next = '0;
        end else if (cd_flip) begin
            deb_next = ~deb_reg;
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            deb_reg   <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= cd_async;
            sync2_reg <= sync1_reg;
            deb_reg   <= deb_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign cd_debounced = deb_reg;

endmodule

// File: rtl/oled_gpio_sequencer.sv
// oled_gpio_sequencer
// Maps PS GPIO control/status words onto the PMOD OLED/SD pins, with a
// hardware display reset sequencer (ASSERT -> WAIT -> READY), N_CS
// active-low chip selects, a debounced card-detect with sticky change event
// and a registered level interrupt.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   gpio_oled_control  : control word (DC, manual reset, reset request,
//                        event clear, CS selects, irq enable)
//   gpio_oled_status   : status word, combinational view of internal state;
//                        upper half carries SIGNATURE
//   oled_sd_cd         : asynchronous card-detect pin
//   oled_rst           : display reset, active-low (registered)
//   oled_dc            : data/command select (registered)
//   oled_cs_n          : chip selects, active-low (registered)
//   irq                : cd_event & irq enable (registered)
module oled_gpio_sequencer
    import oled_gpio_pkg::*;
#(
    parameter int          RST_PULSE_CYCLES = 10000,
    parameter int          RST_WAIT_CYCLES  = 10000,
    parameter int          DEBOUNCE_CYCLES  = 1024,
    parameter int          N_CS             = 2,
    parameter logic [15:0] SIGNATURE        = 16'hDEAD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     gpio_oled_control,
    output logic [31:0]     gpio_oled_status,
    input  logic            oled_sd_cd,
    output logic            oled_rst,
    output logic            oled_dc,
    output logic [N_CS-1:0] oled_cs_n,
    output logic            irq
);

    localparam int CNT_W = $clog2(max_int(RST_PULSE_CYCLES, RST_WAIT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(RST_PULSE_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(RST_WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    logic             req_prev_reg;
    logic             clr_prev_reg;
    logic             req_rise;
    logic             clr_rise;

    logic             oled_rst_reg;
    logic             oled_dc_reg;
    logic [N_CS-1:0]  cs_n_reg;
    logic [N_CS-1:0]  cs_n_next;
    logic             irq_reg;
    logic             cd_event_reg;

    logic             cd_debounced;
    logic             cd_flip;
    logic             busy;
    logic             ready;
    logic             cnt_done;

    // Control bits that have no function here
    logic             unused_ctrl_bits;
    assign unused_ctrl_bits = ^gpio_oled_control[CTRL_IRQ_EN-1:CTRL_CS_BASE+N_CS];

    oled_cd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cd_debounce (
        .clk          (clk),
        .rst          (rst),
        .cd_async     (oled_sd_cd),
        .cd_debounced (cd_debounced),
        .cd_flip      (cd_flip)
    );

    // Previous-value registers reset to 1, so a bit already high when rst
    // is released is not mistaken for a fresh request.
    assign req_rise = gpio_oled_control[CTRL_RST_REQ] & ~req_prev_reg;
    assign clr_rise = gpio_oled_control[CTRL_CD_CLR]  & ~clr_prev_reg;

    assign ready = (state_reg == ST_READY);
    assign busy  = ~ready;

    // Treat 0 as done as well so a corrupted counter can never wrap.
    assign cnt_done = (cnt_reg <= CNT_ONE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_ASSERT: begin
                if (cnt_done) begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (cnt_done) begin
                    state_next = ST_READY;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_READY: begin
                if (req_rise) begin
                    state_next = ST_ASSERT;
                    cnt_next   = PULSE_LOAD;
                end
            end
            default: begin
                state_next = ST_ASSERT;
                cnt_next   = PULSE_LOAD;
            end
        endcase
    end

    // Chip selects are only released to software while the display is ready.
    generate
        for (genvar gi = 0; gi < N_CS; gi++) begin : g_cs
            assign cs_n_next[gi] = ready ? ~gpio_oled_control[CTRL_CS_BASE+gi] : 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_ASSERT;
            cnt_reg      <= PULSE_LOAD;
            req_prev_reg <= 1'b1;
            clr_prev_reg <= 1'b1;
            oled_rst_reg <= 1'b0;
            oled_dc_reg  <= 1'b0;
            cs_n_reg     <= '1;
            irq_reg      <= 1'b0;
            cd_event_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            req_prev_reg <= gpio_oled_control[CTRL_RST_REQ];
            clr_prev_reg <= gpio_oled_control[CTRL_CD_CLR];
            // Outputs follow the current state, one cycle behind it.
            oled_rst_reg <= ready ? ~gpio_oled_control[CTRL_RST_MAN]
                                  : (state_reg == ST_WAIT);
            oled_dc_reg  <= gpio_oled_control[CTRL_DC];
            cs_n_reg     <= cs_n_next;
            irq_reg      <= cd_event_reg & gpio_oled_control[CTRL_IRQ_EN];
            // A new change outranks a simultaneous clear.
            if (cd_flip) begin
                cd_event_reg <= 1'b1;
            end else if (clr_rise) begin
                cd_event_reg <= 1'b0;
            end
        end
    end

    assign oled_rst  = oled_rst_reg;
    assign oled_dc   = oled_dc_reg;
    assign oled_cs_n = cs_n_reg;
    assign irq       = irq_reg;

    assign gpio_oled_status = {SIGNATURE, 8'h00, state_reg, ready, cd_event_reg,
                               busy, oled_rst_reg, oled_dc_reg, cd_debounced};

endmodule

// File: tb/tb_oled_gpio_sequencer.sv
module tb_oled_gpio_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic        sd_cd;
    logic        oled_rst;
    logic        oled_dc;
    logic [1:0]  oled_cs_n;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int SEL_STATUS = 0;
    localparam int SEL_RST    = 1;
    localparam int SEL_DC     = 2;
    localparam int SEL_CS     = 3;
    localparam int SEL_IRQ    = 4;
    localparam int SEL_CD     = 5;
    localparam int SEL_EVT    = 6;
    localparam int SEL_READY  = 7;
    localparam int SEL_BUSY   = 8;
    localparam int SEL_STATE  = 9;

    localparam logic [31:0] STATUS_RESET = 32'hDEAD_0009;
    localparam logic [31:0] STATUS_READY = 32'hDEAD_00A5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    oled_gpio_sequencer #(
        .RST_PULSE_CYCLES (8),
        .RST_WAIT_CYCLES  (5),
        .DEBOUNCE_CYCLES  (4),
        .N_CS             (2),
        .SIGNATURE        (16'hDEAD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .gpio_oled_control (ctrl),
        .gpio_oled_status  (status),
        .oled_sd_cd        (sd_cd),
        .oled_rst          (oled_rst),
        .oled_dc           (oled_dc),
        .oled_cs_n         (oled_cs_n),
        .irq               (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_STATUS: return status;
            SEL_RST:    return {31'd0, oled_rst};
            SEL_DC:     return {31'd0, oled_dc};
            SEL_CS:     return {30'd0, oled_cs_n};
            SEL_IRQ:    return {31'd0, irq};
            SEL_CD:     return {31'd0, status[0]};
            SEL_EVT:    return {31'd0, status[4]};
            SEL_READY:  return {31'd0, status[5]};
            SEL_BUSY:   return {31'd0, status[3]};
            SEL_STATE:  return {30'd0, status[7:6]};
            default:    return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Advance one clock and score every expectation queued for that edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        check("signature", {16'd0, status[31:16]}, 32'h0000_DEAD);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic expect_reset_outputs(input string pfx);
        expect_out({pfx, "_status"}, SEL_STATUS, STATUS_RESET);
        expect_out({pfx, "_rst"},    SEL_RST,    0);
        expect_out({pfx, "_dc"},     SEL_DC,     0);
        expect_out({pfx, "_cs"},     SEL_CS,     3);
        expect_out({pfx, "_irq"},    SEL_IRQ,    0);
    endtask

    // Full power-up sequence: 8 cycles low, 5 high, then ready.
    task automatic run_powerup(input string pfx);
        for (int k = 1; k <= 13; k++) begin
            expect_out($sformatf("%s_rst%0d", pfx, k),   SEL_RST,   (k <= 8) ? 0 : 1);
            expect_out($sformatf("%s_ready%0d", pfx, k), SEL_READY, (k == 13) ? 1 : 0);
            expect_out($sformatf("%s_cs%0d", pfx, k),    SEL_CS,    3);
            if (k == 13)
                expect_out({pfx, "_status"}, SEL_STATUS, STATUS_READY);
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        ctrl  = 32'h0000_0011;
        sd_cd = 1'b1;

        // Reset state; DC must stay low in reset even with control[0] set
        tick();
        expect_reset_outputs("reset");
        tick();

        ctrl = 32'h0;
        rst  = 1'b0;
        run_powerup("pu");

        // READY: DC and chip selects follow control, manual reset
        ctrl = 32'h0000_0011;
        expect_out("ready_dc", SEL_DC, 1);
        expect_out("ready_cs", SEL_CS, 2);
        expect_out("ready_rst_hi", SEL_RST, 1);
        tick();
        ctrl = 32'h0000_0013;
        expect_out("man_rst_lo", SEL_RST, 0);
        tick();
        ctrl = 32'h0000_0011;
        expect_out("man_rst_hi", SEL_RST, 1);
        tick();

        // Reset request in READY; second request during WAIT is ignored
        ctrl = 32'h0000_0015;
        expect_out("req_busy", SEL_BUSY, 1);
        expect_out("req_state", SEL_STATE, 0);
        expect_out("req_rst", SEL_RST, 1);
        tick();
        for (int k = 1; k <= 14; k++) begin
            ctrl = (k == 10) ? 32'h0000_0015 : 32'h0000_0011;
            if (k <= 13)
                expect_out($sformatf("rq_rst%0d", k), SEL_RST, (k <= 8) ? 0 : 1);
            expect_out($sformatf("rq_busy%0d", k),  SEL_BUSY,  (k < 13) ? 1 : 0);
            expect_out($sformatf("rq_ready%0d", k), SEL_READY, (k >= 13) ? 1 : 0);
            expect_out($sformatf("rq_cs%0d", k),    SEL_CS,    (k <= 13) ? 3 : 2);
            tick();
        end

        // Debounce: a 3-cycle glitch is rejected
        ctrl = 32'h8000_0011;
        for (int k = 1; k <= 11; k++) begin
            sd_cd = (k <= 3) ? 1'b0 : 1'b1;
            expect_out($sformatf("glitch_cd%0d", k),  SEL_CD,  1);
            expect_out($sformatf("glitch_evt%0d", k), SEL_EVT, 0);
            expect_out($sformatf("glitch_irq%0d", k), SEL_IRQ, 0);
            tick();
        end

        // Sustained low: level flips after 2 + 4 + 1 edges, irq one later
        for (int k = 1; k <= 8; k++) begin
            sd_cd = 1'b0;
            expect_out($sformatf("low_cd%0d", k),  SEL_CD,  (k < 7) ? 1 : 0);
            expect_out($sformatf("low_evt%0d", k), SEL_EVT, (k >= 7) ? 1 : 0);
            expect_out($sformatf("low_irq%0d", k), SEL_IRQ, (k >= 8) ? 1 : 0);
            tick();
        end

        // Clear collides with the next change (set wins), then clear alone
        for (int k = 1; k <= 12; k++) begin
            sd_cd = 1'b1;
            ctrl  = (k == 7 || k == 10) ? 32'h8000_0019 : 32'h8000_0011;
            expect_out($sformatf("col_cd%0d", k),  SEL_CD,  (k < 7) ? 0 : 1);
            expect_out($sformatf("col_evt%0d", k), SEL_EVT, (k < 10) ? 1 : 0);
            expect_out($sformatf("col_irq%0d", k), SEL_IRQ, (k <= 10) ? 1 : 0);
            if (k == 7)
                expect_out("col_status", SEL_STATUS, 32'hDEAD_00B7);
            tick();
        end

        // Reset asserted mid-WAIT
        ctrl = 32'h8000_0015;
        tick();
        for (int k = 1; k <= 10; k++) begin
            ctrl = 32'h8000_0011;
            if (k == 10)
                expect_out("midwait_state", SEL_STATE, 1);
            tick();
        end
        rst  = 1'b1;
        ctrl = 32'h0;
        expect_reset_outputs("midrst");
        tick();

        // Request bit held high across release: sequence completes, stays READY
        rst  = 1'b0;
        ctrl = 32'h0000_0004;
        run_powerup("rerun");
        expect_out("hold_ready", SEL_READY, 1);
        expect_out("hold_status", SEL_STATUS, STATUS_READY);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
